stream_tracker: RTL and testbench

//  - Downstream sink/checker for the generator's valid/ready stream; sits directly after the generator's output register slice.
//  - Accepts words, checks them against an expected incrementing sequence, and counts accepted words and mismatches.
//  - Applies a programmable backpressure pattern so upstream stall handling is exercised.

---
 rtl/stream_tracker_pkg.sv | 15 +
 rtl/lfsr16.sv | 32 +++
 rtl/stream_tracker.sv | 118 +++++++++++
 tb/tb_stream_tracker.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_tracker_pkg.sv
// Shared types and constants for the stream_tracker sink/checker.
// FSM encoding is kept as plain localparams so legacy code can compare against raw values.
package stream_tracker_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT  = 2'd0;
    localparam state_t ST_READY = 2'd1;
    localparam state_t ST_STALL = 2'd2;

    // x^16 + x^14 + x^13 + x^11 + 1, expressed as a mask over q[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to randomise backpressure in stream_tracker.
// Shifts left, feedback enters at bit 0; holds its value while en is low.
module lfsr16
    import stream_tracker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/stream_tracker.sv
// Valid/ready sink that checks an incrementing data sequence and applies backpressure.
// Define STREAM_TRACKER_RANDOM_STALL_EN to add LFSR-driven random stalls while in READY.
module stream_tracker
    import stream_tracker_pkg::*;
#(
    parameter int            DW        = 16,
    parameter int            DELAY     = 0,
    parameter int            CNT_W     = 32,
    parameter logic [DW-1:0] START_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [DW-1:0]    up_data,
    output logic             up_ready,
    output logic [CNT_W-1:0] rcv_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [DW-1:0]    exp_data
);

    // Counter only needs to hold DELAY-1; keep at least one bit for DELAY<=1.
    localparam int SC_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    state_t           state_q,     state_d;
    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] rcv_q,       rcv_d;
    logic [CNT_W-1:0] err_q,       err_d;
    logic             err_flag_q,  err_flag_d;
    logic [DW-1:0]    exp_q,       exp_d;
    logic             ready_en;
    logic             accept;

`ifdef STREAM_TRACKER_RANDOM_STALL_EN
    logic [15:0] lfsr;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (state_q != ST_INIT),
        .q   (lfsr)
    );

    assign ready_en = ~lfsr[0];
`else
    assign ready_en = 1'b1;
`endif

    // Only registered state feeds up_ready, so there is no path from up_valid.
    assign up_ready = (state_q == ST_READY) && ready_en;
    assign accept   = up_valid && up_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_INIT: state_d = ST_READY;
            ST_READY: begin
                if (accept && (DELAY > 0)) begin
                    state_d     = ST_STALL;
                    stall_cnt_d = SC_W'(DELAY - 1);
                end
            end
            ST_STALL: begin
                if (stall_cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    stall_cnt_d = stall_cnt_q - SC_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Resync on every accepted word so a single gap is reported once.
    always_comb begin
        rcv_d      = rcv_q;
        err_d      = err_q;
        err_flag_d = err_flag_q;
        exp_d      = exp_q;
        if (accept) begin
            rcv_d = rcv_q + CNT_W'(1);
            exp_d = up_data + DW'(1);
            if (up_data != exp_q) begin
                err_flag_d = 1'b1;
                if (err_q != '1) begin
                    err_d = err_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_INIT;
            stall_cnt_q <= '0;
            rcv_q       <= '0;
            err_q       <= '0;
            err_flag_q  <= 1'b0;
            exp_q       <= START_VAL;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            rcv_q       <= rcv_d;
            err_q       <= err_d;
            err_flag_q  <= err_flag_d;
            exp_q       <= exp_d;
        end
    end

    assign rcv_count = rcv_q;
    assign err_count = err_q;
    assign err_flag  = err_flag_q;
    assign exp_data  = exp_q;

endmodule

// File: tb/tb_stream_tracker.sv
// Self-checking bench for stream_tracker: three configurations checked every cycle
// against a transaction-level model, plus hand-computed expectations for each scenario.
module tb_stream_tracker;

    localparam int N = 3;

    typedef struct {
        logic        init;
        int          stall;
        logic [31:0] rcv;
        logic [31:0] err;
        logic        flag;
        logic [15:0] exp;
        logic [15:0] lfsr;
    } model_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_v   = 3'b111;
    logic [2:0]  valid_v = 3'b000;
    logic [15:0] data_v [N];
    logic [2:0]  rdy_v;
    logic [2:0]  flg_v;
    logic [15:0] expd_v [N];
    logic [31:0] rcv_a, err_a, rcv_c, err_c;
    logic [3:0]  rcv_b, err_b;
    logic [31:0] act_rcv [N];
    logic [31:0] act_err [N];

    model_t m [N];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: DELAY=2, 4-bit counters, start near wrap. Instance 2: DELAY=3.
    stream_tracker #(.DELAY(0)) u_a (
        .clk(clk), .rst(rst_v[0]), .up_valid(valid_v[0]), .up_data(data_v[0]),
        .up_ready(rdy_v[0]), .rcv_count(rcv_a), .err_count(err_a),
        .err_flag(flg_v[0]), .exp_data(expd_v[0]));

    stream_tracker #(.DELAY(2), .CNT_W(4), .START_VAL(16'hFFFE)) u_b (
        .clk(clk), .rst(rst_v[1]), .up_valid(valid_v[1]), .up_data(data_v[1]),
        .up_ready(rdy_v[1]), .rcv_count(rcv_b), .err_count(err_b),
        .err_flag(flg_v[1]), .exp_data(expd_v[1]));

    stream_tracker #(.DELAY(3)) u_c (
        .clk(clk), .rst(rst_v[2]), .up_valid(valid_v[2]), .up_data(data_v[2]),
        .up_ready(rdy_v[2]), .rcv_count(rcv_c), .err_count(err_c),
        .err_flag(flg_v[2]), .exp_data(expd_v[2]));

    assign act_rcv[0] = rcv_a;
    assign act_rcv[1] = {28'd0, rcv_b};
    assign act_rcv[2] = rcv_c;
    assign act_err[0] = err_a;
    assign act_err[1] = {28'd0, err_b};
    assign act_err[2] = err_c;

    function automatic int p_delay(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    function automatic logic [31:0] p_mask(input int i);
        return (i == 1) ? 32'h0000_000F : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [15:0] p_start(input int i);
        return (i == 1) ? 16'hFFFE : 16'h0000;
    endfunction

    function automatic model_t reset_model(input int i);
        model_t s;
        s.init  = 1'b1;
        s.stall = 0;
        s.rcv   = '0;
        s.err   = '0;
        s.flag  = 1'b0;
        s.exp   = p_start(i);
        s.lfsr  = 16'hACE1;
        return s;
    endfunction

    function automatic logic ready_of(input model_t s);
`ifdef STREAM_TRACKER_RANDOM_STALL_EN
        return !s.init && (s.stall == 0) && !s.lfsr[0];
`else
        return !s.init && (s.stall == 0);
`endif
    endfunction

    function automatic logic m_ready(input int i);
        return !rst_v[i] && ready_of(m[i]);
    endfunction

    // One clock of the sink: the word is taken if offered while ready, then DELAY dead cycles follow.
    function automatic model_t step(input model_t s, input int i, input logic v, input logic [15:0] d);
        model_t n;
        logic   acc;
        n   = s;
        acc = v && ready_of(s);
        if (!s.init) begin
            n.lfsr = {s.lfsr[14:0], s.lfsr[15] ^ s.lfsr[13] ^ s.lfsr[12] ^ s.lfsr[10]};
            if (s.stall > 0) n.stall = s.stall - 1;
        end
        n.init = 1'b0;
        if (acc) begin
            n.rcv = (s.rcv + 32'd1) & p_mask(i);
            if (d != s.exp) begin
                n.flag = 1'b1;
                if (s.err != p_mask(i)) n.err = s.err + 32'd1;
            end
            n.exp = d + 16'd1;
            if (p_delay(i) > 0) n.stall = p_delay(i);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            m[i] <= rst_v[i] ? reset_model(i) : step(m[i], i, valid_v[i], data_v[i]);
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, want);
        end
    endtask

    // Every-cycle comparison; while reset is held the expectation is the reset state itself.
    always @(negedge clk) begin : cmp
        model_t e;
        logic   er;
        for (int i = 0; i < N; i++) begin
            e  = rst_v[i] ? reset_model(i) : m[i];
            er = m_ready(i);
            check("up_ready",  i, {31'd0, rdy_v[i]}, {31'd0, er});
            check("rcv_count", i, act_rcv[i],        e.rcv);
            check("err_count", i, act_err[i],        e.err);
            check("err_flag",  i, {31'd0, flg_v[i]}, {31'd0, e.flag});
            check("exp_data",  i, {16'd0, expd_v[i]}, {16'd0, e.exp});
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic do_reset(input int i);
        rst_v[i]   = 1'b1;
        valid_v[i] = 1'b0;
        @(posedge clk); #1;
        rst_v[i]   = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!m_ready(i) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_ready", i, {31'd0, m_ready(i)}, 32'd1);
    endtask

    task automatic send(input int i, input logic [15:0] v, output int cyc);
        logic took;
        cyc  = 0;
        took = 1'b0;
        valid_v[i] = 1'b1;
        data_v[i]  = v;
        while (!took && cyc < 100) begin
            took = m_ready(i);
            @(posedge clk); #1;
            cyc++;
        end
        valid_v[i] = 1'b0;
        check("send_accepted", i, {31'd0, took}, 32'd1);
    endtask

    initial begin
        int total;
        int c;
        int acc;
        logic took;
        for (int i = 0; i < N; i++) data_v[i] = 16'h0;

        // Reset state held across two edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   0, {31'd0, rdy_v[0]}, 32'd0);
        check("rst_rcv",     0, rcv_a,             32'd0);
        check("rst_err",     0, err_a,             32'd0);
        check("rst_flag",    0, {31'd0, flg_v[0]}, 32'd0);
        check("rst_exp",     0, {16'd0, expd_v[0]}, 32'd0);
        check("rst_exp",     1, {16'd0, expd_v[1]}, 32'h0000_FFFE);
        rst_v = 3'b000;

        // DELAY=0 streaming: one word per cycle.
        wait_ready(0);
        total = 0;
        for (int v = 0; v < 100; v++) begin
            send(0, 16'(v), c);
            total += c;
        end
`ifndef STREAM_TRACKER_RANDOM_STALL_EN
        check("a_cycles", 0, 32'(total), 32'd100);
`endif
        check("a_rcv",  0, rcv_a,             32'd100);
        check("a_err",  0, err_a,             32'd0);
        check("a_flag", 0, {31'd0, flg_v[0]}, 32'd0);
        check("a_exp",  0, {16'd0, expd_v[0]}, 32'd100);

        // Gap in the sequence counts once and the tracker resyncs.
        do_reset(0);
        wait_ready(0);
        send(0, 16'd0, c); send(0, 16'd1, c); send(0, 16'd2, c); send(0, 16'd5, c);
        check("seq_err5",  0, err_a,             32'd1);
        check("seq_flag5", 0, {31'd0, flg_v[0]}, 32'd1);
        check("seq_exp5",  0, {16'd0, expd_v[0]}, 32'd6);
        send(0, 16'd6, c); send(0, 16'd7, c);
        check("seq_err7",  0, err_a,             32'd1);
        check("seq_exp7",  0, {16'd0, expd_v[0]}, 32'd8);
        check("seq_rcv7",  0, rcv_a,             32'd6);

        // Random traffic with idle gaps and occasional corrupt words.
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                data_v[0] = 16'($urandom);
                @(posedge clk); #1;
            end
            send(0, ($urandom_range(0, 7) == 0) ? 16'($urandom) : m[0].exp, c);
        end

        // Sequence wraps through FFFF without error.
        wait_ready(1);
        send(1, 16'hFFFE, c); send(1, 16'hFFFF, c); send(1, 16'h0000, c);
        check("wrap_err",  1, {28'd0, err_b},    32'd0);
        check("wrap_flag", 1, {31'd0, flg_v[1]}, 32'd0);
        check("wrap_exp",  1, {16'd0, expd_v[1]}, 32'd1);
        check("wrap_rcv",  1, {28'd0, rcv_b},    32'd3);

        // DELAY=2 with continuous valid: ready pattern 1,0,0.
        do_reset(1);
        wait_ready(1);
        acc = 0;
        valid_v[1] = 1'b1;
        data_v[1]  = 16'hFFFE;
        for (int k = 0; k < 30; k++) begin
`ifndef STREAM_TRACKER_RANDOM_STALL_EN
            check("stall_pattern", 1, {31'd0, rdy_v[1]}, (k % 3 == 0) ? 32'd1 : 32'd0);
`endif
            took = m_ready(1);
            @(posedge clk); #1;
            if (took) begin
                acc++;
                data_v[1] = data_v[1] + 16'd1;
            end
        end
        valid_v[1] = 1'b0;
`ifndef STREAM_TRACKER_RANDOM_STALL_EN
        check("stall_accepts", 1, 32'(acc), 32'd10);
        check("stall_rcv",     1, {28'd0, rcv_b}, 32'd10);
`endif
        check("stall_err", 1, {28'd0, err_b}, 32'd0);

        // Saturating error counter and wrapping word counter at 4 bits.
        do_reset(1);
        wait_ready(1);
        for (int k = 0; k < 20; k++) begin
            send(1, 16'(32'h1000 + 2 * k), c);
            if (k == 13) check("sat_err14", 1, {28'd0, err_b}, 32'd14);
            if (k == 14) check("sat_err15", 1, {28'd0, err_b}, 32'd15);
        end
        check("sat_err",  1, {28'd0, err_b},    32'd15);
        check("sat_flag", 1, {31'd0, flg_v[1]}, 32'd1);
        check("sat_rcv",  1, {28'd0, rcv_b},    32'd4);

        // Reset asserted while stalling with DELAY=3.
        wait_ready(2);
        send(2, 16'd0, c);
        send(2, 16'd1, c);
        check("pre_rst_rcv",   2, rcv_c,             32'd2);
        check("pre_rst_ready", 2, {31'd0, rdy_v[2]}, 32'd0);
        #2;
        rst_v[2] = 1'b1;
        #1;
        check("mid_rst_ready", 2, {31'd0, rdy_v[2]}, 32'd0);
        check("mid_rst_rcv",   2, rcv_c,             32'd0);
        check("mid_rst_exp",   2, {16'd0, expd_v[2]}, 32'd0);
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        check("rel_ready0", 2, {31'd0, rdy_v[2]}, 32'd0);
        @(posedge clk); #1;
`ifndef STREAM_TRACKER_RANDOM_STALL_EN
        check("rel_ready1", 2, {31'd0, rdy_v[2]}, 32'd1);
`endif
        check("rel_rcv", 2, rcv_c, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
